// File: rtl/byte_fifo_pkg.sv
// byte_fifo_pkg: default FIFO dimensions and pointer/count width helper.
//   DATA_W_DEF : default entry width in bits
//   DEPTH_DEF  : default number of entries (power of 2, >= 2)
//   ptr_w()    : pointer width for a given depth; the count is one bit wider
package byte_fifo_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 8;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/byte_fifo_mem.sv
// byte_fifo_mem: DEPTH x DATA_W register file, one write port, one registered read port.
//   clk, reset        : clock, synchronous active-high reset (clears read register only)
//   we_i/waddr_i/wdata_i : synchronous write port
//   re_i/raddr_i      : read request/address; rdata_o updates after the edge
//   rdata_o           : registered read data, holds when re_i is low
module byte_fifo_mem
   import byte_fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ptr_w(DEPTH_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (reset) rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous single-clock byte FIFO with registered read data and status flags.
//   clk, reset : clock, synchronous active-high reset
//   writeEn    : push request, dataIn captured when not FULL
//   readEn     : pop request, dataOut updated after the edge when not EMPTY
//   dataIn     : write data
//   dataOut    : registered read data, holds when no read is accepted
//   EMPTY/FULL : derived from the registered entry count
//   OVERFLOW/UNDERFLOW : sticky error flags, present only with BYTE_FIFO_ERR_FLAGS_EN defined
module byte_fifo
   import byte_fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              writeEn,
   input  logic              readEn,
   input  logic [DATA_W-1:0] dataIn,
   output logic [DATA_W-1:0] dataOut,
   output logic              EMPTY,
   output logic              FULL
`ifdef BYTE_FIFO_ERR_FLAGS_EN
   ,
   output logic              OVERFLOW,
   output logic              UNDERFLOW
`endif
);
   localparam int ADDR_W = ptr_w(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              wr_ok, rd_ok;

   assign EMPTY = (count_q == '0);
   assign FULL  = (count_q == CNT_W'(DEPTH));
   assign wr_ok = writeEn & ~FULL;
   assign rd_ok = readEn & ~EMPTY;

   always_comb begin
      wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = (wr_ok && !rd_ok) ? count_q + 1'b1 :
                 (rd_ok && !wr_ok) ? count_q - 1'b1 : count_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Reset gates the write so storage is never touched in a reset cycle.
   byte_fifo_mem #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) u_mem (
      .clk    (clk),
      .reset  (reset),
      .we_i   (wr_ok & ~reset),
      .waddr_i(wr_ptr_q),
      .wdata_i(dataIn),
      .re_i   (rd_ok),
      .raddr_i(rd_ptr_q),
      .rdata_o(dataOut)
   );

`ifdef BYTE_FIFO_ERR_FLAGS_EN
   logic ovf_q, unf_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_q | (writeEn & FULL);
         unf_q <= unf_q | (readEn & EMPTY);
      end
   end

   assign OVERFLOW  = ovf_q;
   assign UNDERFLOW = unf_q;
`endif
endmodule

// File: tb/tb_byte_fifo.sv
// tb_byte_fifo: directed and randomized checks of byte_fifo against a queue-based model.
module tb_byte_fifo;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       writeEn = 1'b0;
   logic       readEn = 1'b0;
   logic [7:0] dataIn = '0;
   logic [7:0] dataOut;
   logic       EMPTY, FULL;
`ifdef BYTE_FIFO_ERR_FLAGS_EN
   logic       OVERFLOW, UNDERFLOW;
   logic       m_ovf = 1'b0, m_unf = 1'b0;
`endif

   int checks = 0;
   int failures = 0;

   logic [7:0] m_q[$];
   logic [7:0] m_dout = '0;

   byte_fifo dut (
      .clk    (clk),
      .reset  (reset),
      .writeEn(writeEn),
      .readEn (readEn),
      .dataIn (dataIn),
      .dataOut(dataOut),
      .EMPTY  (EMPTY),
      .FULL   (FULL)
`ifdef BYTE_FIFO_ERR_FLAGS_EN
      ,
      .OVERFLOW (OVERFLOW),
      .UNDERFLOW(UNDERFLOW)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive on the falling edge, advance the model at the rising edge, compare just after.
   task automatic step(input logic rst, input logic we, input logic re, input logic [7:0] din);
      bit full, empty;
      @(negedge clk);
      reset = rst; writeEn = we; readEn = re; dataIn = din;
      @(posedge clk);
      full  = (m_q.size() == 8);
      empty = (m_q.size() == 0);
      if (rst) begin
         m_q.delete();
         m_dout = '0;
`ifdef BYTE_FIFO_ERR_FLAGS_EN
         m_ovf = 1'b0; m_unf = 1'b0;
`endif
      end else begin
`ifdef BYTE_FIFO_ERR_FLAGS_EN
         if (we && full) m_ovf = 1'b1;
         if (re && empty) m_unf = 1'b1;
`endif
         if (re && !empty) m_dout = m_q.pop_front();
         if (we && !full) m_q.push_back(din);
      end
      #1;
      check("dataOut", 32'(dataOut), 32'(m_dout));
      check("EMPTY", 32'(EMPTY), 32'(m_q.size() == 0));
      check("FULL", 32'(FULL), 32'(m_q.size() == 8));
`ifdef BYTE_FIFO_ERR_FLAGS_EN
      check("OVERFLOW", 32'(OVERFLOW), 32'(m_ovf));
      check("UNDERFLOW", 32'(UNDERFLOW), 32'(m_unf));
`endif
   endtask

   initial begin
      logic [7:0] pat [8] = '{8'd255, 8'd165, 8'd109, 8'd165, 8'd109, 8'd255, 8'd165, 8'd109};
      logic [7:0] last;
      step(1, 0, 0, 0);
      step(1, 1, 1, 8'hAA);
      check("reset_dataOut", 32'(dataOut), 32'h0);
      check("reset_EMPTY", 32'(EMPTY), 32'h1);
      check("reset_FULL", 32'(FULL), 32'h0);

      foreach (pat[i]) step(0, 1, 0, pat[i]);
      check("full_after_8", 32'(FULL), 32'h1);
      step(0, 1, 0, 8'd255);
      check("full_after_drop", 32'(FULL), 32'h1);

      foreach (pat[i]) begin
         step(0, 0, 1, 0);
         check("read_order", 32'(dataOut), 32'(pat[i]));
      end
      check("empty_after_8", 32'(EMPTY), 32'h1);

      last = dataOut;
      step(0, 0, 1, 0);
      check("read_empty_hold", 32'(dataOut), 32'(last));
      step(0, 1, 1, 8'h3C);
      check("wr_rd_empty_no_bypass", 32'(dataOut), 32'(last));
      step(0, 0, 1, 0);
      check("wr_rd_empty_data", 32'(dataOut), 32'h3C);

      for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(8'h10 + i));
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 1, 8'(8'h20 + i));
         check("wrap_count4", 32'(m_q.size()), 32'd4);
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 0);
         check("wrap_order", 32'(dataOut), 32'(8'h26 + i));
      end

      for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h40 + i));
      step(0, 1, 1, 8'hEE);
      check("full_wr_rd_read", 32'(dataOut), 32'h40);
      check("full_wr_rd_not_full", 32'(FULL), 32'h0);
      while (m_q.size() > 0) step(0, 0, 1, 0);

      for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h50 + i));
      step(0, 0, 1, 0);
      step(1, 1, 1, 8'h77);
      check("midreset_EMPTY", 32'(EMPTY), 32'h1);
      check("midreset_dataOut", 32'(dataOut), 32'h0);
      step(0, 1, 0, 8'h99);
      step(0, 0, 1, 0);
      check("post_reset_data", 32'(dataOut), 32'h99);

      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 55,
              $urandom_range(0, 99) < 50, 8'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
